// File: rtl/disp_codec.sv
// disp_codec: double-dabble BCD conversion of two values into 8 active-low
// seven-segment bytes for the bike meter scan driver.
// Ports: clk, rst (sync, active-high), start, val0/val1 [W-1:0] in;
//   busy, done, ovf[1:0], seg0..seg7 [7:0] out (seg0 = leftmost digit).
// Optional macro LZB_EN: enables leading-zero blanking.
module disp_codec #(
  parameter int W   = 14,
  parameter int DP0 = 1,
  parameter int DP1 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] val0,
  input  logic [W-1:0] val1,
  output logic         busy,
  output logic         done,
  output logic [1:0]   ovf,
  output logic [7:0]   seg0,
  output logic [7:0]   seg1,
  output logic [7:0]   seg2,
  output logic [7:0]   seg3,
  output logic [7:0]   seg4,
  output logic [7:0]   seg5,
  output logic [7:0]   seg6,
  output logic [7:0]   seg7
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ENCODE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    bin0_q, bin0_d;
  logic [W-1:0]    bin1_q, bin1_d;
  logic [15:0]     bcd0_q, bcd0_d;
  logic [15:0]     bcd1_q, bcd1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ovfp_q, ovfp_d;
  logic [1:0]      ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0][7:0] seg_q, seg_d;

  logic            sat0, sat1;
  logic [31:0]     enc0, enc1;

  // One double-dabble step: adjust nibbles >= 5, then shift in the next bit.
  function automatic logic [15:0] dd_step(
    input logic [15:0] b,
    input logic        in_bit
  );
    logic [15:0] a;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (a[i*4 +: 4] >= 4'd5)
        a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a[14:0], in_bit};
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Returns 4 bytes, thousands digit in [31:24] down to units in [7:0].
  function automatic logic [31:0] enc_val(
    input logic [15:0] bcd,
    input int          dp
  );
    logic [31:0] o;
    logic [7:0]  s;
`ifdef LZB_EN
    logic        lead;
    lead = 1'b1;
`endif
    o = '0;
    for (int k = 3; k >= 0; k--) begin
      s = seg_of(bcd[k*4 +: 4]);
      if (k == dp)
        s[7] = 1'b0;
`ifdef LZB_EN
      // lead stays set while this and all higher digits are zero
      lead = lead && (bcd[k*4 +: 4] == 4'd0);
      if (lead && k > 0 && k > dp)
        s = 8'hFF;
`endif
      o[k*8 +: 8] = s;
    end
    return o;
  endfunction

  assign sat0 = 32'(val0) > 32'd9999;
  assign sat1 = 32'(val1) > 32'd9999;
  assign enc0 = enc_val(bcd0_q, DP0);
  assign enc1 = enc_val(bcd1_q, DP1);

  always_comb begin
    state_d = state_q;
    bin0_d  = bin0_q;
    bin1_d  = bin1_q;
    bcd0_d  = bcd0_q;
    bcd1_d  = bcd1_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin0_d  = sat0 ? W'(9999) : val0;
          bin1_d  = sat1 ? W'(9999) : val1;
          ovfp_d  = {sat1, sat0};
          bcd0_d  = '0;
          bcd1_d  = '0;
          cnt_d   = CW'(W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd0_d = dd_step(bcd0_q, bin0_q[W-1]);
        bcd1_d = dd_step(bcd1_q, bin1_q[W-1]);
        bin0_d = {bin0_q[W-2:0], 1'b0};
        bin1_d = {bin1_q[W-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = ENCODE;
      end
      ENCODE: begin
        seg_d[0] = enc0[31:24];
        seg_d[1] = enc0[23:16];
        seg_d[2] = enc0[15:8];
        seg_d[3] = enc0[7:0];
        seg_d[4] = enc1[31:24];
        seg_d[5] = enc1[23:16];
        seg_d[6] = enc1[15:8];
        seg_d[7] = enc1[7:0];
        ovf_d    = ovfp_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin0_q  <= '0;
      bin1_q  <= '0;
      bcd0_q  <= '0;
      bcd1_q  <= '0;
      cnt_q   <= '0;
      ovfp_q  <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= {8{8'hFF}};
    end else begin
      state_q <= state_d;
      bin0_q  <= bin0_d;
      bin1_q  <= bin1_d;
      bcd0_q  <= bcd0_d;
      bcd1_q  <= bcd1_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule

// File: tb/tb_disp_codec.sv
// tb_disp_codec: scoreboard bench for disp_codec.
// Directed vectors; expected segment bytes hand-computed per build.
module tb_disp_codec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] val0, val1;
  logic        busy, done;
  logic [1:0]  ovf;
  logic [7:0]  seg0, seg1, seg2, seg3;
  logic [7:0]  seg4, seg5, seg6, seg7;

  disp_codec dut (
    .clk(clk), .rst(rst), .start(start),
    .val0(val0), .val1(val1),
    .busy(busy), .done(done), .ovf(ovf),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] seg;
    logic [1:0]  ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  int   n_push = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] segs();
    return {seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // monitor: pops an expectation every time done is seen
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done got=1 want=0 at cyc %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("segs", segs(), e.seg);
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // start edge is the next posedge; done is visible 16 negedges later
  task automatic pulse(input logic [13:0] v0, input logic [13:0] v1,
                       input bit expect_done,
                       input logic [63:0] es, input logic [1:0] eo);
    exp_t e;
    @(negedge clk);
    val0 = v0;
    val1 = v1;
    start = 1'b1;
    if (expect_done) begin
      e.seg = es;
      e.ovf = eo;
      e.cyc = cyc + 16;
      q.push_back(e);
      n_push++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout got=busy want=idle");
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  logic [63:0] e_1234_567, e_0_0, e_5_10;

  initial begin
`ifdef LZB_EN
    e_1234_567 = 64'hF9A4_3099_FF12_82F8;
    e_0_0      = 64'hFFFF_40C0_FF40_C0C0;
    e_5_10     = 64'hFFFF_4092_FF40_F9C0;
`else
    e_1234_567 = 64'hF9A4_3099_C012_82F8;
    e_0_0      = 64'hC0C0_40C0_C040_C0C0;
    e_5_10     = 64'hC0C0_4092_C040_F9C0;
`endif
    rst = 1'b1;
    start = 1'b1;
    val0 = 14'd4321;
    val1 = 14'd8765;
    repeat (2) @(negedge clk);
    chk("rst_segs", segs(), {8{8'hFF}});
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_ign", 64'(busy), 64'd0);

    pulse(14'd1234, 14'd567, 1'b1, e_1234_567, 2'b00);
    wait_idle();
    pulse(14'd12000, 14'd9999, 1'b1,
          64'h9090_1090_9010_9090, 2'b01);
    wait_idle();
    pulse(14'd16383, 14'd16383, 1'b1,
          64'h9090_1090_9010_9090, 2'b11);
    wait_idle();
    pulse(14'd0, 14'd0, 1'b1, e_0_0, 2'b00);
    wait_idle();
    pulse(14'd5, 14'd10, 1'b1, e_5_10, 2'b00);
    wait_idle();

    // second start while busy must be ignored
    pulse(14'd1111, 14'd1111, 1'b1,
          64'hF9F9_79F9_F979_F9F9, 2'b00);
    repeat (3) @(negedge clk);
    pulse(14'd2222, 14'd2222, 1'b0, '0, 2'b00);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("hold_segs", segs(), 64'hF9F9_79F9_F979_F9F9);

    // reset mid-conversion aborts with no done pulse
    pulse(14'd1234, 14'd567, 1'b0, '0, 2'b00);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_segs", segs(), {8{8'hFF}});
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);

    pulse(14'd1234, 14'd567, 1'b1, e_1234_567, 2'b00);
    wait_idle();

    chk("done_count", 64'(n_done), 64'(n_push));
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
